fxp_alu_seq: RTL
================

FXP_ALU_SEQ -- requirements
Module: fxp_alu_seq

Interface
REQ-001 SHALL have parameter N, default 32, total word width in bits (sign + magnitude).
REQ-002 SHALL have parameter Q, default 15, number of fractional bits (legal range 1 to N-2).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  operation request, sampled on rising clk.
REQ-006 SHALL have port a  input  N  operand A, sign-magnitude, sign at bit N-1, Q fractional bits.
REQ-007 SHALL have port b  input  N  operand B, same format as a.
REQ-008 SHALL have port opcode  input  2  00 add, 01 sub (a-b), 10 mul, 11 div (a/b).
REQ-009 SHALL have port c  output  N  result, same format as a.
REQ-010 SHALL have port done_flag  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port busy  output  1  high while an operation is in progress.
REQ-012 SHALL have port ovf  output  1  result magnitude exceeded N-1 bits.
REQ-013 SHALL have port div0  output  1  division with zero divisor magnitude.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE; IDLE->CALC on start, CALC->DONE when iteration count expires, DONE->IDLE unconditionally.
REQ-015 SHALL capture a, b, opcode only on a clk edge in IDLE with start=1; later operand changes SHALL NOT affect the result.
REQ-016 SHALL ignore start while busy=1 or in DONE (no queuing, no restart).
REQ-017 SHALL assert busy from the cycle after the accepting edge until done_flag asserts; busy and done_flag SHALL never both be high.
REQ-018 SHALL assert done_flag exactly L cycles after the accepting edge: L=2 add/sub, L=N mul (N-1 shift-add iterations), L=N+Q div (N-1+Q restoring iterations).
REQ-019 SHALL update c, ovf, div0 in the same cycle done_flag asserts and hold them until the next done_flag or reset.
REQ-020 Add/sub SHALL operate on magnitudes: equal signs add, differing signs subtract smaller from larger taking sign of larger; sub inverts b sign first.
REQ-021 Mul SHALL form the 2(N-1)-bit magnitude product, shift right by Q (truncate), sign = sign(a) XOR sign(b).
REQ-022 Div SHALL compute floor((|a| << Q) / |b|), sign = sign(a) XOR sign(b).
REQ-023 ovf SHALL be 1 when the true magnitude needs more than N-1 bits (add carry-out, mul/div nonzero high bits).
REQ-024 div0 SHALL be 1 when opcode=11 and |b|=0; ovf SHALL then also be 1 and no iterations change the latency (still L=N+Q).
REQ-025 A zero magnitude result SHALL always have sign bit 0 (no negative zero).
REQ-026 Back-to-back: start high in the IDLE cycle following DONE SHALL be accepted.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE and c=0, done_flag=0, busy=0, ovf=0, div0=0, independent of clk.
REQ-028 Reset during CALC or DONE SHALL abort the operation with no done_flag; first start after release SHALL behave as from power-up.

Configuration
REQ-029 Macro FXP_ALU_SAT_EN defined: on ovf, c magnitude SHALL saturate to all ones (N-1 bits) with computed sign; div0 gives max magnitude with sign(a).
REQ-030 Macro FXP_ALU_SAT_EN undefined: on ovf, c SHALL carry the low N-1 magnitude bits (wrap) with computed sign; div0 gives c=0; ovf/div0 flag behaviour unchanged.

Verification (N=32, Q=15)
REQ-031 add a=0x0000C000 (1.5), b=0x00012000 (2.25) -> c=0x0001E000 (3.75), done_flag 2 cycles after start, ovf=0.
REQ-032 mul a=0x0000C000 (1.5), b=0x80010000 (-2.0) -> c=0x80018000 (-3.0), done_flag 32 cycles after start.
REQ-033 div a=0x00008000 (1.0), b=0x00020000 (4.0) -> c=0x00002000 (0.25) at 47 cycles; div b=0 with a=0x00008000 -> div0=1, ovf=1, c=0x7FFFFFFF (SAT) / 0x00000000 (no SAT).
REQ-034 mul a=0x4E200000 (40000.0), b=0x00010000 (2.0) -> ovf=1, c=0x7FFFFFFF with FXP_ALU_SAT_EN, c=0x1C400000 without.
REQ-035 add a=0x0000C000, b=0x8000C000 -> c=0x00000000 (sign 0); start pulsed again mid-mul -> ignored, single done_flag, result unchanged.
REQ-036 rst_n low for one cycle at cycle 10 of a div -> all outputs 0 immediately, no done_flag; next add completes correctly in 2 cycles.

Source files
------------

// File: rtl/fxp_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : fxp_alu_seq
// Brief    : Sequential sign-magnitude fixed-point ALU (add/sub/mul/div).
//            The multiplier is shift-add and the divider is restoring; both
//            run one iteration per clock.
// Option   : FXP_ALU_SAT_EN - saturate the result on overflow or divide by
//            zero. Without it, overflow wraps and divide by zero returns 0.
// Revision : 1.0 - initial release
// ============================================================================
module fxp_alu_seq #(
  parameter int N = 32,
  parameter int Q = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   opcode,
  output logic [N-1:0] c,
  output logic         done_flag,
  output logic         busy,
  output logic         ovf,
  output logic         div0
);

  localparam int M  = N - 1;                // magnitude width
  localparam int DW = N - 1 + Q;            // dividend / quotient width
  localparam int CW = $clog2(N + Q + 1);    // cycle counter width

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     op_q, op_d;
  logic           sa_q, sa_d;
  logic           sb_q, sb_d;                // b sign, already inverted for sub
  logic [M-1:0]   ma_q, ma_d;
  logic [M-1:0]   mb_q, mb_d;
  logic [M-1:0]   p_hi_q, p_hi_d;            // product upper half
  logic [M-1:0]   p_lo_q, p_lo_d;            // multiplier bits / product lower half
  logic [M-1:0]   rem_q, rem_d;              // restoring-division remainder
  logic [DW-1:0]  quo_q, quo_d;              // dividend shifting out, quotient in
  logic [N-1:0]   c_q, c_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           ovf_q, ovf_d;
  logic           div0_q, div0_d;

  logic [N-1:0]   mul_sum;
  logic [N-1:0]   div_trial;
  logic           div_fit;
  logic [M-1:0]   div_rem;
  logic [N-1:0]   as_sum;
  logic           a_ge_b;
  logic [M-1:0]   as_diff;
  logic [2*M-1:0] prod_sh;
  logic [M-1:0]   res_mag;
  logic           res_sign;
  logic           res_ovf;
  logic           res_dz;
  logic [N-1:0]   res_word;

  // One shift-add step, one restoring-division step, and the add/sub datapath
  always_comb begin
    mul_sum   = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, ma_q} : {N{1'b0}});
    div_trial = {rem_q, quo_q[DW-1]};
    div_fit   = (div_trial >= {1'b0, mb_q});
    // When the divisor fits the difference is below 2^M, so M-bit math is exact
    div_rem   = div_fit ? (div_trial[M-1:0] - mb_q) : div_trial[M-1:0];
    as_sum    = {1'b0, ma_q} + {1'b0, mb_q};
    a_ge_b    = (ma_q >= mb_q);
    as_diff   = a_ge_b ? (ma_q - mb_q) : (mb_q - ma_q);
  end

  // Final result, overflow and divide-by-zero from the finished datapath state
  always_comb begin
    prod_sh  = {p_hi_q, p_lo_q} >> Q;
    res_mag  = '0;
    res_sign = 1'b0;
    res_ovf  = 1'b0;
    res_dz   = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        if (sa_q == sb_q) begin
          res_mag  = as_sum[M-1:0];
          res_ovf  = as_sum[M];
          res_sign = sa_q;
        end else begin
          res_mag  = as_diff;
          res_sign = a_ge_b ? sa_q : sb_q;
        end
      end
      OP_MUL: begin
        res_mag  = prod_sh[M-1:0];
        res_ovf  = |prod_sh[2*M-1:M];
        res_sign = sa_q ^ sb_q;
      end
      default: begin
        res_dz   = (mb_q == '0);
        res_mag  = quo_q[M-1:0];
        res_ovf  = (|quo_q[DW-1:M]) | res_dz;
        res_sign = sa_q ^ sb_q;
      end
    endcase
`ifdef FXP_ALU_SAT_EN
    if (res_dz) begin
      res_word = {sa_q, {M{1'b1}}};
    end else if (res_ovf) begin
      res_word = {res_sign, {M{1'b1}}};
    end else begin
      res_word = {res_sign & (|res_mag), res_mag};
    end
`else
    // Wrapped results keep the computed sign unless the kept bits are zero
    if (res_dz) begin
      res_word = '0;
    end else begin
      res_word = {res_sign & (|res_mag), res_mag};
    end
`endif
  end

  // Control FSM next state: accept in IDLE, iterate in CALC, one-cycle DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    c_d     = c_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    div0_d  = div0_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          busy_d  = 1'b1;
          op_d    = opcode;
          sa_d    = a[N-1];
          sb_d    = b[N-1] ^ (opcode == OP_SUB);
          ma_d    = a[N-2:0];
          mb_d    = b[N-2:0];
          p_hi_d  = '0;
          p_lo_d  = b[N-2:0];
          rem_d   = '0;
          quo_d   = {a[N-2:0], {Q{1'b0}}};
          // Cycles until done: one per iteration plus the result cycle
          cnt_d   = (opcode == OP_MUL) ? CW'(N)
                  : (opcode == OP_DIV) ? CW'(N + Q)
                  : CW'(2);
        end
      end
      CALC: begin
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          c_d     = res_word;
          ovf_d   = res_ovf;
          div0_d  = res_dz;
        end else begin
          cnt_d  = cnt_q - CW'(1);
          p_hi_d = mul_sum[M:1];
          p_lo_d = {mul_sum[0], p_lo_q[M-1:1]};
          rem_d  = div_rem;
          quo_d  = {quo_q[DW-2:0], div_fit};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; asynchronous reset aborts any operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      c_q     <= c_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      div0_q  <= div0_d;
    end
  end

  assign c         = c_q;
  assign done_flag = done_q;
  assign busy      = busy_q;
  assign ovf       = ovf_q;
  assign div0      = div0_q;

endmodule
`default_nettype wire
